chess_turn_controller: RTL and testbench
========================================

Name: chess_turn_controller

Overview:
- Game sequencer for the chess clock.
- Decides which player's timer counts, hands the turn over on player button presses, and supports pause/resume.
- Latches end-of-game and the winner from the two timers' OVERFLOW flags.
- Sits between the debounced front-panel inputs and the two player countdown timers. It drives their load, enable and bonus-increment controls.

Parameters:
- MOVE_W, 8, width of the full-move counter MOVES.
- INC_EN, 1, 1 = generate INC1/INC2 bonus pulses on hand-off; 0 = INC1/INC2 tied 0.

Ports:
- CLK  in  1  system clock
- CLR  in  1  asynchronous active-high reset
- CE  in  1  one-cycle timebase tick (e.g. 1 Hz / 10 Hz) gating timer enables
- START  in  1  debounced level; rising edge starts a new game / leaves DONE
- PAUSE  in  1  debounced level; rising edge toggles pause
- BTN1  in  1  debounced level; player 1 "move done" button
- BTN2  in  1  debounced level; player 2 "move done" button
- OVERFLOW1  in  1  player 1 timer expired (synchronous level)
- OVERFLOW2  in  1  player 2 timer expired (synchronous level)
- EN1  out  1  count enable, player 1 timer
- EN2  out  1  count enable, player 2 timer
- LOAD  out  1  preset both timers
- INC1  out  1  one-cycle bonus pulse, player 1 timer
- INC2  out  1  one-cycle bonus pulse, player 2 timer
- TURN  out  1  0 = player 1 to move, 1 = player 2 to move
- RUNNING  out  1  clock running (RUN1 or RUN2)
- END  out  1  game over
- WINNER  out  2  bit0 = player 1 wins, bit1 = player 2 wins; 11 = both flags (fault/draw)
- MOVES  out  MOVE_W  completed full moves

Behaviour:
- All state updates on posedge CLK. CLR is asynchronous, active-high, and overrides everything.
- Edge detect: rise = input high AND registered previous value low. The previous-value registers reset to 1, so a button held through reset release generates no edge.
- States: IDLE, RUN1, RUN2, PAUSED, DONE. Reset state is IDLE. A registered side bit records the paused side.
- Reset output values:
  - LOAD = 1 (IDLE decode).
  - EN1, EN2, INC1, INC2, TURN, RUNNING, END = 0.
  - WINNER = 00, MOVES = 0.
- IDLE:
  - LOAD = 1.
  - START rise -> RUN1; MOVES cleared to 0; WINNER cleared.
  - BTN, PAUSE and OVERFLOW are ignored.
- RUN1:
  - EN1 = CE, combinational from the registered state.
  - BTN1 rise -> RUN2, with INC1 = 1 for the transition cycle.
  - BTN2 is ignored.
- RUN2:
  - EN2 = CE.
  - BTN2 rise -> RUN1, with INC2 = 1 for the transition cycle.
  - MOVES += 1 on this transition, saturating at 2^MOVE_W-1.
  - BTN1 is ignored.
- PAUSED:
  - EN1 = EN2 = 0.
  - PAUSE rise -> back to the saved side (RUN1 or RUN2).
  - Buttons are ignored.
- Pause entry: PAUSE rise in RUN1/RUN2 -> PAUSED; side bit = current TURN.
- Overflow, checked in RUN1, RUN2 and PAUSED: OVERFLOW1 OR OVERFLOW2 high -> DONE next cycle.
  - WINNER registered as {OVERFLOW1, OVERFLOW2} sampled in that cycle.
  - EN of an overflowing player is forced 0 combinationally in that same cycle.
- Priority within one cycle: overflow > pause > button. A button rise coinciding with an overflow gives no INC pulse and no MOVES change.
- DONE:
  - END = 1; EN1, EN2 = 0; WINNER and MOVES held.
  - START rise -> IDLE.
  - Other inputs ignored.
- Decodes:
  - TURN = 1 in RUN2, or in PAUSED with side = 1; otherwise 0.
  - RUNNING = RUN1 OR RUN2.
- CE low does not stall the FSM; it only gates EN1/EN2.

Test Plan:
1. Reset release with BTN1 held high -> state IDLE, LOAD = 1, no INC pulse, MOVES = 0.
2. START rise, then 3 CE ticks, then BTN1 rise, then 2 CE ticks, then BTN2 rise:
   - EN1 pulses 3 times; INC1 one cycle; TURN goes 1.
   - EN2 pulses 2 times; INC2 one cycle; MOVES = 1; TURN goes 0.
3. In RUN2: PAUSE rise, 5 CE ticks, BTN2 rise, PAUSE rise:
   - No EN pulses and no state change during pause.
   - Returns to RUN2 with TURN = 1.
4. In RUN1: OVERFLOW1 = 1 together with BTN1 rise -> DONE, END = 1, WINNER = 10, no INC1, EN1 = 0.
5. In PAUSED: OVERFLOW1 and OVERFLOW2 both high -> DONE, WINNER = 11. Then START rise -> IDLE, LOAD = 1, END = 0.
6. MOVE_W = 2; perform 5 full moves -> MOVES saturates at 3. Assert CLR mid-RUN2 -> immediate IDLE, all outputs at reset values.

Source files
------------

// File: rtl/chess_turn_controller.sv
// Chess clock game sequencer: decides whose timer runs, hands the turn over on
// button presses, supports pause/resume and latches the winner on timer expiry.
module chess_turn_controller #(
  parameter int MOVE_W = 8,
  parameter bit INC_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              START,
  input  logic              PAUSE,
  input  logic              BTN1,
  input  logic              BTN2,
  input  logic              OVERFLOW1,
  input  logic              OVERFLOW2,
  output logic              EN1,
  output logic              EN2,
  output logic              LOAD,
  output logic              INC1,
  output logic              INC2,
  output logic              TURN,
  output logic              RUNNING,
  output logic              END,
  output logic [1:0]        WINNER,
  output logic [MOVE_W-1:0] MOVES
);

  typedef enum logic [2:0] {IDLE, RUN1, RUN2, PAUSED, DONE} state_t;

  state_t              state, next_state;
  logic                side, next_side;
  logic [1:0]          next_winner;
  logic [MOVE_W-1:0]   next_moves;
  logic                start_prev, pause_prev, btn1_prev, btn2_prev;
  logic                start_rise, pause_rise, btn1_rise, btn2_rise;
  logic                ovf;

  // Previous-value registers reset high so a level held through reset is not an edge
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      btn1_prev  <= 1'b1;
      btn2_prev  <= 1'b1;
    end else begin
      start_prev <= START;
      pause_prev <= PAUSE;
      btn1_prev  <= BTN1;
      btn2_prev  <= BTN2;
    end
  end

  assign start_rise = START & ~start_prev;
  assign pause_rise = PAUSE & ~pause_prev;
  assign btn1_rise  = BTN1  & ~btn1_prev;
  assign btn2_rise  = BTN2  & ~btn2_prev;
  assign ovf        = OVERFLOW1 | OVERFLOW2;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      side   <= 1'b0;
      WINNER <= 2'b00;
      MOVES  <= '0;
    end else begin
      state  <= next_state;
      side   <= next_side;
      WINNER <= next_winner;
      MOVES  <= next_moves;
    end
  end

  // Overflow beats pause, pause beats a button press within the same cycle
  always_comb begin
    next_state  = state;
    next_side   = side;
    next_winner = WINNER;
    next_moves  = MOVES;
    EN1         = 1'b0;
    EN2         = 1'b0;
    INC1        = 1'b0;
    INC2        = 1'b0;
    LOAD        = 1'b0;
    END         = 1'b0;
    unique case (state)
      IDLE: begin
        LOAD = 1'b1;
        if (start_rise) begin
          next_state  = RUN1;
          next_moves  = '0;
          next_winner = 2'b00;
        end
      end
      RUN1: begin
        EN1 = CE & ~OVERFLOW1;
        if (ovf) begin
          next_state  = DONE;
          next_winner = {OVERFLOW1, OVERFLOW2};
        end else if (pause_rise) begin
          next_state = PAUSED;
          next_side  = 1'b0;
        end else if (btn1_rise) begin
          next_state = RUN2;
          INC1       = INC_EN;
        end
      end
      RUN2: begin
        EN2 = CE & ~OVERFLOW2;
        if (ovf) begin
          next_state  = DONE;
          next_winner = {OVERFLOW1, OVERFLOW2};
        end else if (pause_rise) begin
          next_state = PAUSED;
          next_side  = 1'b1;
        end else if (btn2_rise) begin
          next_state = RUN1;
          INC2       = INC_EN;
          if (MOVES != {MOVE_W{1'b1}})
            next_moves = MOVES + MOVE_W'(1);
        end
      end
      PAUSED: begin
        if (ovf) begin
          next_state  = DONE;
          next_winner = {OVERFLOW1, OVERFLOW2};
        end else if (pause_rise) begin
          next_state = side ? RUN2 : RUN1;
        end
      end
      DONE: begin
        END = 1'b1;
        if (start_rise)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign TURN    = (state == RUN2) | ((state == PAUSED) & side);
  assign RUNNING = (state == RUN1) | (state == RUN2);

endmodule

// File: tb/tb_chess_turn_controller.sv
// Directed plus randomized bench for chess_turn_controller against a game-level
// reference model (in-game / paused / over flags, whose turn, move count).
module tb_chess_turn_controller;

  logic       CLK, CLR, CE, START, PAUSE, BTN1, BTN2, OVERFLOW1, OVERFLOW2;
  logic       EN1, EN2, LOAD, INC1, INC2, TURN, RUNNING, END;
  logic [1:0] WINNER;
  logic [1:0] MOVES;

  int checks = 0;
  int errors = 0;

  // Reference model: game flags rather than a state machine
  bit         mInGame, mPaused, mOver, mTurn;
  int         mMoves;
  logic [1:0] mWin;
  bit         pStart, pPause, pBtn1, pBtn2;

  chess_turn_controller #(.MOVE_W(2), .INC_EN(1'b1)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .START(START), .PAUSE(PAUSE),
    .BTN1(BTN1), .BTN2(BTN2), .OVERFLOW1(OVERFLOW1), .OVERFLOW2(OVERFLOW2),
    .EN1(EN1), .EN2(EN2), .LOAD(LOAD), .INC1(INC1), .INC2(INC2),
    .TURN(TURN), .RUNNING(RUNNING), .END(END), .WINNER(WINNER), .MOVES(MOVES)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic modelReset();
    mInGame = 0; mPaused = 0; mOver = 0; mTurn = 0;
    mMoves = 0; mWin = 2'b00;
    pStart = 1; pPause = 1; pBtn1 = 1; pBtn2 = 1;
  endtask

  // Compare every output against the model, then advance the model one clock
  task automatic checkOutput(input bit advance);
    bit sR, pR, b1R, b2R, run, ov, i1, i2;
    sR  = START & !pStart;
    pR  = PAUSE & !pPause;
    b1R = BTN1 & !pBtn1;
    b2R = BTN2 & !pBtn2;
    run = mInGame && !mPaused;
    ov  = mInGame && (OVERFLOW1 || OVERFLOW2);
    i1  = run && !mTurn && b1R && !ov && !pR;
    i2  = run && mTurn && b2R && !ov && !pR;
    compare("EN1", 8'(EN1), 8'(run && !mTurn && CE && !OVERFLOW1));
    compare("EN2", 8'(EN2), 8'(run && mTurn && CE && !OVERFLOW2));
    compare("LOAD", 8'(LOAD), 8'(!mInGame && !mOver));
    compare("INC1", 8'(INC1), 8'(i1));
    compare("INC2", 8'(INC2), 8'(i2));
    compare("TURN", 8'(TURN), 8'(mInGame && mTurn));
    compare("RUNNING", 8'(RUNNING), 8'(run));
    compare("END", 8'(END), 8'(mOver));
    compare("WINNER", 8'(WINNER), 8'(mWin));
    compare("MOVES", 8'(MOVES), 8'(mMoves));
    if (advance) begin
      if (!mInGame && !mOver) begin
        if (sR) begin
          mInGame = 1; mTurn = 0; mPaused = 0; mMoves = 0; mWin = 2'b00;
        end
      end else if (mOver) begin
        if (sR) mOver = 0;
      end else if (ov) begin
        mInGame = 0; mPaused = 0; mOver = 1; mWin = {OVERFLOW1, OVERFLOW2};
      end else if (pR) begin
        mPaused = !mPaused;
      end else if (i1) begin
        mTurn = 1;
      end else if (i2) begin
        mTurn = 0;
        if (mMoves < 3) mMoves++;
      end
      pStart = START; pPause = PAUSE; pBtn1 = BTN1; pBtn2 = BTN2;
    end
  endtask

  // Run n clocks with the current input levels; inputs change only at negedge
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      checkOutput(1'b1);
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic doReset();
    CLR = 1'b1;
    modelReset();
    #1;
    checkOutput(1'b0);
    @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic ceTicks(input int n);
    for (int i = 0; i < n; i++) begin
      CE = 1'b1; applyStimulus(1);
      CE = 1'b0; applyStimulus(1);
    end
  endtask

  initial begin
    CLR = 1'b0; CE = 0; START = 0; PAUSE = 0; BTN1 = 1; BTN2 = 0;
    OVERFLOW1 = 0; OVERFLOW2 = 0;
    @(negedge CLK);
    doReset();
    applyStimulus(2);

    // Start a game; BTN1 still held from reset must not hand over
    START = 1; applyStimulus(1);
    ceTicks(3);
    BTN1 = 0; applyStimulus(1);
    BTN1 = 1; applyStimulus(1);
    ceTicks(2);
    BTN2 = 1; applyStimulus(1);
    BTN1 = 0; BTN2 = 0; applyStimulus(1);

    // Move to RUN2, pause, press buttons while paused, resume
    BTN1 = 1; applyStimulus(1);
    PAUSE = 1; applyStimulus(1);
    ceTicks(5);
    BTN2 = 1; applyStimulus(1);
    PAUSE = 0; BTN2 = 0; applyStimulus(1);
    PAUSE = 1; applyStimulus(1);
    ceTicks(1);

    // Back to RUN1, then overflow together with a button rise
    BTN2 = 1; BTN1 = 0; applyStimulus(1);
    BTN1 = 1; OVERFLOW1 = 1; CE = 1; applyStimulus(1);
    OVERFLOW1 = 0; CE = 0; applyStimulus(2);

    // New game, pause, double overflow, leave DONE
    START = 0; applyStimulus(1);
    START = 1; applyStimulus(1);
    START = 0; applyStimulus(1);
    START = 1; applyStimulus(1);
    PAUSE = 0; applyStimulus(1);
    PAUSE = 1; applyStimulus(1);
    OVERFLOW1 = 1; OVERFLOW2 = 1; applyStimulus(1);
    OVERFLOW1 = 0; OVERFLOW2 = 0; START = 0; applyStimulus(1);
    START = 1; applyStimulus(2);

    // New game, five full moves saturate a 2-bit counter, reset mid-RUN2
    START = 0; applyStimulus(1);
    START = 1; applyStimulus(1);
    for (int m = 0; m < 5; m++) begin
      BTN1 = 0; BTN2 = 0; applyStimulus(1);
      BTN1 = 1; applyStimulus(1);
      BTN2 = 1; applyStimulus(1);
    end
    BTN1 = 0; applyStimulus(1);
    BTN1 = 1; applyStimulus(1);
    doReset();
    applyStimulus(1);

    // Randomized play
    for (int c = 0; c < 1500; c++) begin
      CE        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)  BTN1  = ~BTN1;
      if ($urandom_range(0, 3) == 0)  BTN2  = ~BTN2;
      if ($urandom_range(0, 11) == 0) PAUSE = ~PAUSE;
      if ($urandom_range(0, 19) == 0) START = ~START;
      OVERFLOW1 = ($urandom_range(0, 59) == 0);
      OVERFLOW2 = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 249) == 0) doReset();
      else applyStimulus(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
